// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared types and the test-pattern generator for the RAM self-test controller.
package ram_bist_pkg;

  // Controller phases, in the order a test walks through them.
  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_e;

  // Pattern select codes carried on the mode port.
  typedef enum logic [1:0] {
    MODE_ADDR    = 2'd0,
    MODE_INV     = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_ONES    = 2'd3
  } mode_e;

  // Width of the raw pattern word; callers cast it down to their RAM word width (up to 64 bits).
  localparam int unsigned PAT_W = 64;

  // Word expected at address addr for the selected mode, LSB-aligned.
  function automatic logic [PAT_W-1:0] pat(input logic [31:0] addr, input mode_e mode);
    logic [PAT_W-1:0] a_ext;
    a_ext = {32'h0, addr};
    case (mode)
      MODE_ADDR:    pat = a_ext;
      MODE_INV:     pat = ~a_ext;
      MODE_CHECKER: pat = addr[0] ? {(PAT_W/4){4'b1010}} : {(PAT_W/4){4'b0101}};
      MODE_ONES:    pat = '1;
      default:      pat = '0;
    endcase
  endfunction

endpackage

// File: rtl/ram_bist_rdpipe.sv
// ram_bist_rdpipe: RD_LAT-deep {valid, addr} delay line that tracks each read until its data returns.
module ram_bist_rdpipe
  import ram_bist_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  logic [RD_LAT-1:0] valid_q;
  logic [ADDR_W-1:0] addr_q [RD_LAT];

  // Shift the read tag one stage per cycle; clear drops any in-flight reads.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      addr_q[0]  <= in_addr;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_addr  = addr_q[RD_LAT-1];

endmodule

// File: rtl/ram_sp_bist.sv
// ram_sp_bist: write/read-back self-test controller for one single-port synchronous RAM.
// Fills every address with a selected pattern, reads it back, counts mismatches and
// records the first failing address.
// Build macro BIST_ERR_INJECT_EN adds inj_en/inj_addr, which plant a bit-0 fault in one write.
module ram_sp_bist
  import ram_bist_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ERR_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef BIST_ERR_INJECT_EN
  ,
  input  logic              inj_en,
  input  logic [ADDR_W-1:0] inj_addr
`endif
);

  localparam logic [ADDR_W-1:0]  LAST_ADDR  = '1;
  localparam int unsigned        DRAIN_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(RD_LAT - 1);

  state_e             state;
  mode_e              mode_q;
  logic [DRAIN_W-1:0] drain_cnt;

  logic               pipe_clr;
  logic               pipe_in_valid;
  logic               pipe_valid;
  logic [ADDR_W-1:0]  pipe_addr;

  mode_e              pat_mode;
  logic [ADDR_W-1:0]  wr_addr_nxt;
  logic [DATA_W-1:0]  wr_word_nxt;
  logic [DATA_W-1:0]  rd_expect;
  logic               mismatch;
  logic [ERR_W-1:0]   err_nxt;

`ifdef BIST_ERR_INJECT_EN
  logic               inj_en_q;
  logic [ADDR_W-1:0]  inj_addr_q;
  logic               inj_on;
  logic [ADDR_W-1:0]  inj_at;
`endif

  // Read tags enter the pipe from the registered RAM controls, so they line up with the RAM's own sampling.
  assign pipe_clr      = sys_rst | ((state == IDLE) & start);
  assign pipe_in_valid = ram_en & ~ram_we;

  ram_bist_rdpipe #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_rdpipe (
    .clk       (sys_clk),
    .clr       (pipe_clr),
    .in_valid  (pipe_in_valid),
    .in_addr   (ram_addr),
    .out_valid (pipe_valid),
    .out_addr  (pipe_addr)
  );

  // Next write address/word; in IDLE it is the first word of the test about to start, using the unlatched mode.
  always_comb begin
    pat_mode    = (state == IDLE) ? mode_e'(mode) : mode_q;
    wr_addr_nxt = (state == IDLE) ? '0 : ram_addr + 1'b1;
    wr_word_nxt = DATA_W'(pat(32'(wr_addr_nxt), pat_mode));
`ifdef BIST_ERR_INJECT_EN
    inj_on = (state == IDLE) ? inj_en : inj_en_q;
    inj_at = (state == IDLE) ? inj_addr : inj_addr_q;
    if (inj_on && (wr_addr_nxt == inj_at)) begin
      wr_word_nxt[0] = ~wr_word_nxt[0];
    end
`endif
  end

  // Compare returning read data and form the saturating next error count.
  always_comb begin
    rd_expect = DATA_W'(pat(32'(pipe_addr), mode_q));
    mismatch  = pipe_valid && (ram_rdata != rd_expect);
    err_nxt   = err_cnt;
    if (mismatch && (err_cnt != '1)) begin
      err_nxt = err_cnt + 1'b1;
    end
  end

  // Test sequencer with registered RAM controls and status outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      mode_q     <= MODE_ADDR;
      drain_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_addr  <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
`ifdef BIST_ERR_INJECT_EN
      inj_en_q   <= 1'b0;
      inj_addr_q <= '0;
`endif
    end else begin
      done <= 1'b0;

      // A zero count means nothing has failed yet, so this is the first mismatch.
      if (mismatch) begin
        err_cnt <= err_nxt;
        if (err_cnt == '0) begin
          fail_addr <= pipe_addr;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= WRITE;
            mode_q    <= mode_e'(mode);
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            ram_en    <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= wr_addr_nxt;
            ram_wdata <= wr_word_nxt;
`ifdef BIST_ERR_INJECT_EN
            inj_en_q   <= inj_en;
            inj_addr_q <= inj_addr;
`endif
          end
        end

        WRITE: begin
          if (ram_addr == LAST_ADDR) begin
            state    <= READ;
            ram_we   <= 1'b0;
            ram_addr <= '0;
          end else begin
            ram_addr  <= wr_addr_nxt;
            ram_wdata <= wr_word_nxt;
          end
        end

        READ: begin
          if (ram_addr == LAST_ADDR) begin
            state     <= DRAIN;
            ram_en    <= 1'b0;
            drain_cnt <= '0;
          end else begin
            ram_addr <= ram_addr + 1'b1;
          end
        end

        // The last compare lands on the exit edge, so pass must use the count including it.
        DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_nxt == '0);
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sp_bist.sv
// tb_ram_sp_bist: two controller instances (read latency 1 and 3) each driving a behavioural RAM,
// checked every cycle against a timeline model plus directed literal expectations.
module tb_ram_sp_bist;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int ERR_W  = 16;
  localparam int DEPTH  = 16;
  localparam int RUN_CYCLES = 2*DEPTH + 3 + 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start     [2];
  logic [1:0]        mode      [2];
  logic              busy      [2];
  logic              done      [2];
  logic              pass      [2];
  logic [ERR_W-1:0]  err_cnt   [2];
  logic [ADDR_W-1:0] fail_addr [2];
  logic              ram_en    [2];
  logic              ram_we    [2];
  logic [ADDR_W-1:0] ram_addr  [2];
  logic [DATA_W-1:0] ram_wdata [2];
  logic [DATA_W-1:0] ram_rdata [2];
  logic              inj_en    [2];
  logic [ADDR_W-1:0] inj_addr  [2];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  ram_sp_bist #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1), .ERR_W(ERR_W)) u_dut_l1 (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .start     (start[0]),
    .mode      (mode[0]),
    .busy      (busy[0]),
    .done      (done[0]),
    .pass      (pass[0]),
    .err_cnt   (err_cnt[0]),
    .fail_addr (fail_addr[0]),
    .ram_en    (ram_en[0]),
    .ram_we    (ram_we[0]),
    .ram_addr  (ram_addr[0]),
    .ram_wdata (ram_wdata[0]),
    .ram_rdata (ram_rdata[0])
`ifdef BIST_ERR_INJECT_EN
    ,
    .inj_en    (inj_en[0]),
    .inj_addr  (inj_addr[0])
`endif
  );

  ram_sp_bist #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(3), .ERR_W(ERR_W)) u_dut_l3 (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .start     (start[1]),
    .mode      (mode[1]),
    .busy      (busy[1]),
    .done      (done[1]),
    .pass      (pass[1]),
    .err_cnt   (err_cnt[1]),
    .fail_addr (fail_addr[1]),
    .ram_en    (ram_en[1]),
    .ram_we    (ram_we[1]),
    .ram_addr  (ram_addr[1]),
    .ram_wdata (ram_wdata[1]),
    .ram_rdata (ram_rdata[1])
`ifdef BIST_ERR_INJECT_EN
    ,
    .inj_en    (inj_en[1]),
    .inj_addr  (inj_addr[1])
`endif
  );

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] model_pat(input int a, input int m);
    logic [7:0] v;
    v = 8'(a);
    case (m)
      0:       return v;
      1:       return ~v;
      2:       return (a % 2 == 1) ? 8'hAA : 8'h55;
      default: return 8'hFF;
    endcase
  endfunction

  // Behavioural single-port RAMs; corrupt[i] flips bit 7 of the word returned for marked addresses.
  logic [DATA_W-1:0] mem     [2][DEPTH];
  logic [DATA_W-1:0] rpipe   [2][3];
  logic [DEPTH-1:0]  corrupt [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_en[i] && ram_we[i]) mem[i][ram_addr[i]] <= ram_wdata[i];
      rpipe[i][0] <= (ram_en[i] && !ram_we[i]) ?
                     (mem[i][ram_addr[i]] ^ (corrupt[i][ram_addr[i]] ? 8'h80 : 8'h00)) : 8'h00;
      rpipe[i][1] <= rpipe[i][0];
      rpipe[i][2] <= rpipe[i][1];
    end
  end
  assign ram_rdata[0] = rpipe[0][0];
  assign ram_rdata[1] = rpipe[1][2];

  // Timeline model: phase 0 = cleared, 1 = running (t edges since start accepted), 2 = finished/held.
  int               phase   [2] = '{0, 0};
  int               t       [2] = '{0, 0};
  int               m_mode  [2];
  bit               m_inj   [2];
  int               m_inj_a [2];
  logic [DEPTH-1:0] m_bad   [2];
  int               m_total [2];
  int               m_first [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        phase[i] = 0;
      end else if (phase[i] == 1) begin
        if (t[i] == 2*DEPTH + lat(i)) phase[i] = 2;
        else t[i] = t[i] + 1;
      end else if (start[i]) begin
        phase[i]   = 1;
        t[i]       = 0;
        m_mode[i]  = int'(mode[i]);
        m_inj[i]   = inj_en[i];
        m_inj_a[i] = int'(inj_addr[i]);
        m_bad[i]   = corrupt[i];
`ifdef BIST_ERR_INJECT_EN
        if (m_inj[i]) m_bad[i][m_inj_a[i]] = 1'b1;
`endif
        m_total[i] = 0;
        m_first[i] = 0;
        for (int a = DEPTH - 1; a >= 0; a--) begin
          if (m_bad[i][a]) begin
            m_total[i] = m_total[i] + 1;
            m_first[i] = a;
          end
        end
      end
    end
  end

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[u%0d] at %0t: got 0x%0h, expected 0x%0h", name, inst, $time, act, exp);
    end
  endtask

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        int L, T, cnt, first;
        bit e_busy, e_done, e_pass, e_en, e_we, addr_ok, wd_ok;
        int e_addr;
        logic [7:0] e_wd;
        L = lat(i); T = t[i];
        e_busy = 0; e_done = 0; e_pass = 0; e_en = 0; e_we = 0;
        addr_ok = 0; wd_ok = 0; e_addr = 0; e_wd = 8'h00; cnt = 0; first = 0;
        if (phase[i] == 1) begin
          e_busy = (T < 2*DEPTH + L);
          e_done = (T == 2*DEPTH + L);
          e_pass = e_done && (m_total[i] == 0);
          // Read of address a is issued at T=DEPTH+a; its count update is visible L+1 cycles later.
          for (int a = 0; a < DEPTH; a++) begin
            if (m_bad[i][a] && (DEPTH + 1 + a + L <= T)) begin
              if (cnt == 0) first = a;
              cnt++;
            end
          end
          if (T < DEPTH) begin
            e_en = 1; e_we = 1; addr_ok = 1; wd_ok = 1; e_addr = T;
            e_wd = model_pat(T, m_mode[i]) ^ ((m_inj[i] && T == m_inj_a[i]) ? 8'h01 : 8'h00);
          end else if (T < 2*DEPTH) begin
            e_en = 1; addr_ok = 1; e_addr = T - DEPTH;
          end
        end else if (phase[i] == 2) begin
          e_pass = (m_total[i] == 0);
          cnt = m_total[i];
          first = m_first[i];
        end
        check("busy", i, busy[i], e_busy);
        check("done", i, done[i], e_done);
        check("pass", i, pass[i], e_pass);
        check("err_cnt", i, err_cnt[i], cnt);
        check("fail_addr", i, fail_addr[i], first);
        check("ram_en", i, ram_en[i], e_en);
        check("ram_we", i, ram_we[i], e_we);
        if (addr_ok) check("ram_addr", i, ram_addr[i], e_addr);
        if (wd_ok) check("ram_wdata", i, ram_wdata[i], e_wd);
      end
    end
  end

  // Start a test and watch a fixed window; n counts edges after the accepting edge.
  task automatic run(input int inst, input int m, input bit repulse, input int abort_at,
                     output int done_at, output int ndone);
    @(posedge clk); #2;
    start[inst] = 1'b1;
    mode[inst]  = 2'(m);
    @(posedge clk); #2;
    start[inst] = 1'b0;
    done_at = -1;
    ndone   = 0;
    for (int n = 0; n < RUN_CYCLES; n++) begin
      if (done[inst]) begin
        ndone++;
        if (done_at < 0) done_at = n;
      end
      start[inst] = repulse && (n == 4 || n == 32);
      rst = (n == abort_at);
      @(posedge clk); #2;
    end
    start[inst] = 1'b0;
    rst = 1'b0;
  endtask

  int d_at, d_n;

  initial begin
    rst = 1'b1;
    start = '{0, 0}; mode = '{0, 0}; inj_en = '{0, 0}; inj_addr = '{0, 0};
    corrupt = '{16'h0, 16'h0};
    repeat (3) @(posedge clk);
    #2;
    chk_on = 1'b1;
    rst = 1'b0;
    check("rst_busy", 0, busy[0], 0);
    check("rst_ram_en", 1, ram_en[1], 0);

    // 1: address pattern, latency 1: done 33 edges after accept (cycle 34).
    run(0, 0, 0, -1, d_at, d_n);
    check("t1_done_at", 0, d_at, 33);
    check("t1_pass", 0, pass[0], 1);
    check("t1_err", 0, err_cnt[0], 0);
    check("t1_mem0", 0, mem[0][0], 8'h00);
    check("t1_mem10", 0, mem[0][10], 8'h0A);
    check("t1_mem15", 0, mem[0][15], 8'h0F);

    // 2: checkerboard, latency 3: done at cycle 36.
    run(1, 2, 0, -1, d_at, d_n);
    check("t2_done_at", 1, d_at, 35);
    check("t2_pass", 1, pass[1], 1);
    check("t2_mem5", 1, mem[1][5], 8'hAA);
    check("t2_mem6", 1, mem[1][6], 8'h55);

    // 3: corrupt read data at addresses 3 and 9.
    corrupt[0] = 16'h0208;
    run(0, 0, 0, -1, d_at, d_n);
    corrupt[0] = 16'h0000;
    check("t3_err", 0, err_cnt[0], 2);
    check("t3_fail_addr", 0, fail_addr[0], 3);
    check("t3_pass", 0, pass[0], 0);

    // 4: reset mid-test (cycle 20), then a fresh full test.
    run(0, 1, 0, 19, d_at, d_n);
    check("t4_ndone", 0, d_n, 0);
    check("t4_busy", 0, busy[0], 0);
    check("t4_ram_en", 0, ram_en[0], 0);
    run(0, 3, 0, -1, d_at, d_n);
    check("t4_rerun_done_at", 0, d_at, 33);
    check("t4_rerun_pass", 0, pass[0], 1);

    // 5: start re-pulsed at cycles 5 and 33 is ignored.
    run(0, 1, 1, -1, d_at, d_n);
    check("t5_ndone", 0, d_n, 1);
    check("t5_done_at", 0, d_at, 33);
    check("t5_pass", 0, pass[0], 1);

`ifdef BIST_ERR_INJECT_EN
    // 6: planted write fault at address 0xA.
    inj_en[0] = 1'b1;
    inj_addr[0] = 4'hA;
    run(0, 0, 0, -1, d_at, d_n);
    inj_en[0] = 1'b0;
    check("t6_err", 0, err_cnt[0], 1);
    check("t6_fail_addr", 0, fail_addr[0], 4'hA);
    check("t6_pass", 0, pass[0], 0);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
